pc_sequencer: RTL

//  Parametrised program-counter sequencer for the CPU fetch stage; successor to the single-cycle PC register.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_next_calc.sv | 36 +++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg : next-PC source encodings, sequencer states, default vectors
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_sequencer_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0080;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_next_calc.sv
// ---------------------------------------------------------------------------
// pc_sequencer_next_calc : combinational PC+4, branch/jump/register targets
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer_next_calc #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 26
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  branch_off,
  input  logic [INDEX_W-1:0] jump_index,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic [ADDR_W-1:0]  pc4,
  output logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  j_target,
  output logic [ADDR_W-1:0]  jr_target,
  output logic               misaligned
);

  // All sums truncate to ADDR_W, so wrap-around is intentional.
  assign pc4        = pc + ADDR_W'(4);
  assign br_target  = pc4 + (branch_off << 2);
  assign jr_target  = {reg_target[ADDR_W-1:2], 2'b00};
  assign misaligned = |reg_target[1:0];

  if (INDEX_W + 2 == ADDR_W) begin : g_jump_full
    assign j_target = {jump_index, 2'b00};
  end else begin : g_jump_region
    assign j_target = {pc4[ADDR_W-1:INDEX_W+2], jump_index, 2'b00};
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : fetch-stage PC register with stall, halt/resume, exception vectoring
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               INDEX_W   = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEFAULT_EXC_VEC)
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               PCWre,
  input  logic               Stall,
  input  logic [1:0]         PCSrc,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchOff,
  input  logic [INDEX_W-1:0] JumpIndex,
  input  logic [ADDR_W-1:0]  RegTarget,
  input  logic               HaltReq,
  input  logic               Resume,
  input  logic               Exception,
  output logic [ADDR_W-1:0]  PCOut,
  output logic [ADDR_W-1:0]  PC4,
  output logic [ADDR_W-1:0]  EPC,
  output logic               Halted,
  output logic               AlignFault
);

  pc_state_t         state, next_state;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] pc4, br_target, j_target, jr_target;
  logic              misaligned;

  pc_sequencer_next_calc #(
    .ADDR_W  (ADDR_W),
    .INDEX_W (INDEX_W)
  ) u_next_calc (
    .pc         (pc_q),
    .branch_off (BranchOff),
    .jump_index (JumpIndex),
    .reg_target (RegTarget),
    .pc4        (pc4),
    .br_target  (br_target),
    .j_target   (j_target),
    .jr_target  (jr_target),
    .misaligned (misaligned)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= ST_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= next_state;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      fault_q <= fault_d;
    end
  end

  // Exception bypasses Stall but never PCWre; BOOT ignores Exception/HaltReq.
  always_comb begin
    next_state = state;
    pc_d       = pc_q;
    epc_d      = epc_q;
    fault_d    = 1'b0;
    if (PCWre) begin
      case (state)
        ST_BOOT: begin
          if (!Stall) begin
            pc_d       = RESET_VEC;
            next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (Exception) begin
            epc_d = pc_q;
            pc_d  = EXC_VEC;
          end else if (!Stall) begin
            if (HaltReq) begin
              next_state = ST_HALT;
            end else begin
              case (PCSrc)
                PCSRC_SEQ: pc_d = pc4;
                PCSRC_BR:  pc_d = BranchTaken ? br_target : pc4;
                PCSRC_J:   pc_d = j_target;
                PCSRC_JR: begin
                  pc_d    = jr_target;
                  fault_d = misaligned;
                end
                default:   pc_d = pc4;
              endcase
            end
          end
        end
        ST_HALT: begin
          if (Exception) begin
            epc_d      = pc_q;
            pc_d       = EXC_VEC;
            next_state = ST_RUN;
          end else if (!Stall && Resume) begin
            next_state = ST_RUN;
          end
        end
        default: next_state = ST_BOOT;
      endcase
    end
  end

  assign PCOut      = pc_q;
  assign PC4        = pc4;
  assign EPC        = epc_q;
  assign Halted     = (state == ST_HALT);
  assign AlignFault = fault_q;

endmodule

`default_nettype wire
